alu_operand_collector: RTL and testbench

- Input-side responder for the ALU operand protocol: consumes the OPA/OPB/CIN/MODE/CMD/INP_VALID/CE stream that the bench driver produces.
- Merges split operand deliveries (INP_VALID 01 then 10, or 10 then 01) into one complete operation.
- Presents the complete operation to the ALU execute core as a single-cycle op_valid pulse.
- Enforces the 16-cycle operand timeout with a one-cycle ERR pulse; sits between the pin interface and the execute core.

---
 rtl/alu_operand_collector.sv | 209 ++++++++++++++++++++
 tb/tb_alu_operand_collector.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_operand_collector.sv
// alu_operand_collector: merges split OPA/OPB deliveries of the ALU operand
// protocol into one complete operation and presents it to the execute core
// as a single-cycle op_valid pulse. A wait that sees no arrival for TIMEOUT
// CE-high cycles, or an illegal MODE/CMD pair, produces a one-cycle ERR pulse.
// Optional build macro COLLECT_STATS_EN adds the saturating timeout_cnt output.
module alu_operand_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CE,
  input  logic [DATA_WIDTH-1:0] OPA,
  input  logic [DATA_WIDTH-1:0] OPB,
  input  logic                  CIN,
  input  logic                  MODE,
  input  logic [CMD_WIDTH-1:0]  CMD,
  input  logic [1:0]            INP_VALID,
  output logic                  op_valid,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic                  op_cin,
  output logic                  op_mode,
  output logic [CMD_WIDTH-1:0]  op_cmd,
  output logic                  ERR,
  output logic                  waiting
`ifdef COLLECT_STATS_EN
  ,
  output logic [7:0]            timeout_cnt
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_A = 2'd1, WAIT_B = 2'd2} state_t;

  // Operand requirement {need_b, need_a}; 2'b00 marks an illegal command.
  function automatic logic [1:0] need_ops(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
    int unsigned c;
    logic [1:0]  n;
    c = 32'(cmd);
    n = 2'b00;
    if (mode) begin
      case (c) inside
        [0:3], [8:10]: n = 2'b11;
        [4:5]:         n = 2'b01;
        [6:7]:         n = 2'b10;
        default:       n = 2'b00;
      endcase
    end else begin
      case (c) inside
        [0:5], [12:13]: n = 2'b11;
        6, 8, 9:        n = 2'b01;
        7, 10, 11:      n = 2'b10;
        default:        n = 2'b00;
      endcase
    end
    return n;
  endfunction

`ifdef COLLECT_STATS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] lat_a_q, lat_a_d, lat_b_q, lat_b_d;
  logic [CMD_WIDTH-1:0]  lat_cmd_q, lat_cmd_d;
  logic                  lat_mode_q, lat_mode_d, lat_cin_q, lat_cin_d;
  logic                  op_valid_q, op_valid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CMD_WIDTH-1:0]  op_cmd_q, op_cmd_d;
  logic                  op_cin_q, op_cin_d, op_mode_q, op_mode_d;
  logic [7:0]            tcnt_q, tcnt_d;
  logic [1:0]            need;
  logic                  timed_out;

  // Next-state, capture and pulse generation; everything holds while CE is low.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_a_d    = lat_a_q;
    lat_b_d    = lat_b_q;
    lat_cmd_d  = lat_cmd_q;
    lat_mode_d = lat_mode_q;
    lat_cin_d  = lat_cin_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_cmd_d   = op_cmd_q;
    op_cin_d   = op_cin_q;
    op_mode_d  = op_mode_q;
    op_valid_d = 1'b0;
    err_d      = 1'b0;
    tcnt_d     = tcnt_q;
    timed_out  = 1'b0;
    need       = need_ops(MODE, CMD);
    if (CE) begin
      case (state_q)
        IDLE: begin
          if (INP_VALID != 2'b00) begin
            if (need == 2'b00) begin
              err_d = 1'b1;
            end else if ((INP_VALID & need) == need) begin
              op_a_d     = OPA;
              op_b_d     = OPB;
              op_cmd_d   = CMD;
              op_mode_d  = MODE;
              op_cin_d   = CIN;
              op_valid_d = 1'b1;
            end else if (need == 2'b11) begin
              // Half of a two-operand op: hold it until the partner shows up.
              lat_a_d    = OPA;
              lat_b_d    = OPB;
              lat_cmd_d  = CMD;
              lat_mode_d = MODE;
              lat_cin_d  = CIN;
              cnt_d      = '0;
              state_d    = INP_VALID[0] ? WAIT_B : WAIT_A;
            end
          end
        end
        WAIT_A, WAIT_B: begin
          if ((state_q == WAIT_B) ? INP_VALID[1] : INP_VALID[0]) begin
            // Arrival wins even on the cycle that would otherwise time out.
            op_a_d     = (state_q == WAIT_A) ? OPA : lat_a_q;
            op_b_d     = (state_q == WAIT_B) ? OPB : lat_b_q;
            op_cmd_d   = lat_cmd_q;
            op_mode_d  = lat_mode_q;
            op_cin_d   = lat_cin_q;
            op_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_d      = 1'b1;
            timed_out  = 1'b1;
            cnt_d      = '0;
            lat_a_d    = '0;
            lat_b_d    = '0;
            lat_cmd_d  = '0;
            lat_mode_d = 1'b0;
            lat_cin_d  = 1'b0;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef COLLECT_STATS_EN
    if (timed_out) tcnt_d = sat_inc8(tcnt_q);
`else
    tcnt_d = tcnt_q & {8{timed_out}};
`endif
  end

  // All state registers; reset clears control, latches and outputs alike.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_a_q    <= '0;
      lat_b_q    <= '0;
      lat_cmd_q  <= '0;
      lat_mode_q <= 1'b0;
      lat_cin_q  <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_cmd_q   <= '0;
      op_cin_q   <= 1'b0;
      op_mode_q  <= 1'b0;
      op_valid_q <= 1'b0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_a_q    <= lat_a_d;
      lat_b_q    <= lat_b_d;
      lat_cmd_q  <= lat_cmd_d;
      lat_mode_q <= lat_mode_d;
      lat_cin_q  <= lat_cin_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_cmd_q   <= op_cmd_d;
      op_cin_q   <= op_cin_d;
      op_mode_q  <= op_mode_d;
      op_valid_q <= op_valid_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign op_valid = op_valid_q;
  assign ERR      = err_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_cmd   = op_cmd_q;
  assign op_cin   = op_cin_q;
  assign op_mode  = op_mode_q;
  assign waiting  = (state_q == WAIT_A) || (state_q == WAIT_B);
`ifdef COLLECT_STATS_EN
  assign timeout_cnt = tcnt_q;
`endif

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector: expected operations are queued
// when the completing beat is driven and popped whenever op_valid appears.
// Honors COLLECT_STATS_EN for the timeout_cnt port.
module tb_alu_operand_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       CE = 1'b0;
  logic [7:0] OPA = '0, OPB = '0;
  logic       CIN = 1'b0, MODE = 1'b0;
  logic [3:0] CMD = '0;
  logic [1:0] INP_VALID = '0;
  logic       op_valid, op_cin, op_mode, ERR, waiting;
  logic [7:0] op_a, op_b;
  logic [3:0] op_cmd;
`ifdef COLLECT_STATS_EN
  logic [7:0] timeout_cnt;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] cmd;
    logic       mode;
    logic       cin;
  } op_t;

  op_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  alu_operand_collector #(.DATA_WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .CE(CE), .OPA(OPA), .OPB(OPB), .CIN(CIN),
    .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID), .op_valid(op_valid),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_mode(op_mode),
    .op_cmd(op_cmd), .ERR(ERR), .waiting(waiting)
`ifdef COLLECT_STATS_EN
    , .timeout_cnt(timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd,
                          input logic mode, input logic cin);
    op_t e;
    e.a = a; e.b = b; e.cmd = cmd; e.mode = mode; e.cin = cin;
    sb.push_back(e);
  endtask

  // Drive one cycle, then check the pulses/waiting and any produced operation.
  task automatic cyc(input logic ce, input logic [1:0] iv, input logic mode, input logic [3:0] cmd,
                     input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic ev, input logic ee, input logic ew, input string tag);
    op_t e;
    CE = ce; INP_VALID = iv; MODE = mode; CMD = cmd; OPA = a; OPB = b; CIN = cin;
    @(posedge clk);
    #1;
    chk({tag, ":op_valid"}, op_valid, ev);
    chk({tag, ":ERR"}, ERR, ee);
    chk({tag, ":waiting"}, waiting, ew);
    if (op_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, ":sb_nonempty"}, sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk({tag, ":op_a"}, op_a, e.a);
        chk({tag, ":op_b"}, op_b, e.b);
        chk({tag, ":op_cmd"}, op_cmd, e.cmd);
        chk({tag, ":op_mode"}, op_mode, e.mode);
        chk({tag, ":op_cin"}, op_cin, e.cin);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":op_valid"}, op_valid, 0);
    chk({tag, ":ERR"}, ERR, 0);
    chk({tag, ":waiting"}, waiting, 0);
    chk({tag, ":op_a"}, op_a, 0);
    chk({tag, ":op_b"}, op_b, 0);
    chk({tag, ":op_cmd"}, op_cmd, 0);
    chk({tag, ":op_cin"}, op_cin, 0);
    chk({tag, ":op_mode"}, op_mode, 0);
`ifdef COLLECT_STATS_EN
    chk({tag, ":timeout_cnt"}, timeout_cnt, 0);
`endif
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // Both operands at once
    push_exp(8'h12, 8'h34, 4'd0, 1'b1, 1'b0);
    cyc(1, 2'b11, 1, 4'd0, 8'h12, 8'h34, 0, 1, 0, 0, "full");
    cyc(1, 2'b00, 0, 4'd3, 8'hEE, 8'hEE, 1, 0, 0, 0, "full_idle");
    chk("full_hold_a", op_a, 8'h12);

    // A first, three idle wait cycles, then B; late CMD/CIN ignored
    cyc(1, 2'b01, 1, 4'd1, 8'hA5, 8'h00, 1, 0, 0, 1, "splitAB_a");
    for (int i = 0; i < 3; i++) cyc(1, 2'b00, 0, 4'd0, 8'h00, 8'h00, 0, 0, 0, 1, "splitAB_w");
    push_exp(8'hA5, 8'h0F, 4'd1, 1'b1, 1'b1);
    cyc(1, 2'b10, 1, 4'd9, 8'h00, 8'h0F, 0, 1, 0, 0, "splitAB_b");

    // Timeout: B held, A never arrives; re-presenting B does not restart the count
    cyc(1, 2'b10, 0, 4'd0, 8'h00, 8'h55, 1, 0, 0, 1, "to_b");
    for (int i = 1; i <= 15; i++)
      cyc(1, (i == 5) ? 2'b10 : 2'b00, 0, 4'd0, 8'h00, 8'h66, 0, 0, 0, 1, "to_w");
    cyc(1, 2'b00, 0, 4'd0, 8'h00, 8'h00, 0, 0, 1, 0, "to_err");
    cyc(1, 2'b00, 0, 4'd0, 8'h00, 8'h00, 0, 0, 0, 0, "to_after");
`ifdef COLLECT_STATS_EN
    chk("to_stat", timeout_cnt, 1);
`endif

    // Timeout with a 5-cycle CE gap: ERR slips by exactly 5 cycles
    cyc(1, 2'b10, 0, 4'd0, 8'h00, 8'h21, 0, 0, 0, 1, "gto_b");
    for (int i = 0; i < 8; i++) cyc(1, 2'b00, 0, 4'd0, 8'h00, 8'h00, 0, 0, 0, 1, "gto_w1");
    for (int i = 0; i < 5; i++) cyc(0, 2'b11, 1, 4'd0, 8'h77, 8'h77, 1, 0, 0, 1, "gto_ce0");
    for (int i = 0; i < 7; i++) cyc(1, 2'b00, 0, 4'd0, 8'h00, 8'h00, 0, 0, 0, 1, "gto_w2");
    cyc(1, 2'b00, 0, 4'd0, 8'h00, 8'h00, 0, 0, 1, 0, "gto_err");
`ifdef COLLECT_STATS_EN
    chk("gto_stat", timeout_cnt, 2);
`endif

    // Same gap, but A arrives on the 16th wait cycle: arrival wins
    cyc(1, 2'b10, 0, 4'd2, 8'h00, 8'hC3, 1, 0, 0, 1, "arr_b");
    for (int i = 0; i < 8; i++) cyc(1, 2'b00, 0, 4'd0, 8'h00, 8'h00, 0, 0, 0, 1, "arr_w1");
    for (int i = 0; i < 5; i++) cyc(0, 2'b01, 0, 4'd0, 8'h99, 8'h00, 0, 0, 0, 1, "arr_ce0");
    for (int i = 0; i < 7; i++) cyc(1, 2'b00, 0, 4'd0, 8'h00, 8'h00, 0, 0, 0, 1, "arr_w2");
    push_exp(8'h77, 8'hC3, 4'd2, 1'b0, 1'b1);
    cyc(1, 2'b01, 1, 4'd15, 8'h77, 8'h00, 0, 1, 0, 0, "arr_a");

    // Illegal command, then a single-operand command with no wait
    cyc(1, 2'b11, 1, 4'd12, 8'h01, 8'h02, 0, 0, 1, 0, "illegal");
    cyc(1, 2'b00, 1, 4'd12, 8'h01, 8'h02, 0, 0, 0, 0, "illegal_after");
`ifdef COLLECT_STATS_EN
    chk("illegal_stat", timeout_cnt, 2);
`endif
    push_exp(8'h3C, 8'h99, 4'd4, 1'b1, 1'b1);
    cyc(1, 2'b01, 1, 4'd4, 8'h3C, 8'h99, 1, 1, 0, 0, "single_a");
    push_exp(8'h10, 8'h20, 4'd11, 1'b0, 1'b0);
    cyc(1, 2'b10, 0, 4'd11, 8'h10, 8'h20, 0, 1, 0, 0, "single_b_log");

    // Reset during WAIT_B discards the partial operation
    cyc(1, 2'b01, 1, 4'd2, 8'h11, 8'h00, 1, 0, 0, 1, "rst_a");
    reset = 1'b1;
    cyc(1, 2'b00, 0, 4'd0, 8'h00, 8'h00, 0, 0, 0, 0, "rst_edge");
    chk_all_zero("rst_mid");
    reset = 1'b0;
    cyc(1, 2'b10, 1, 4'd2, 8'h00, 8'h22, 0, 0, 0, 1, "rst_newb");
    push_exp(8'h44, 8'h22, 4'd2, 1'b1, 1'b0);
    cyc(1, 2'b01, 0, 4'd0, 8'h44, 8'h00, 1, 1, 0, 0, "rst_newa");

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
